// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin arbiter muxing NUM_CORES cores onto one synchronous-read DRAM.
// Define DRAM_ARB_FIXED_PRIO_EN for fixed priority (core 0 highest) instead of round-robin.
module dram_arbiter #(
   parameter int NUM_CORES = 2,
   parameter int AW = 8,
   parameter int DW = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_CORES-1:0]    rden,
   input  logic [NUM_CORES-1:0]    wren,
   input  logic [NUM_CORES*AW-1:0] Address,
   input  logic [NUM_CORES*DW-1:0] Din,
   input  logic [DW-1:0]           RAMq,
   output logic [NUM_CORES-1:0]    acq,
   output logic [NUM_CORES*DW-1:0] Dq,
   output logic [AW-1:0]           RAMAddress,
   output logic [DW-1:0]           RAMDin,
   output logic                    RAMwren
);
   localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NUM_CORES - 1);
   typedef enum logic [1:0] {IDLE, GRANT, RDATA} state_t;
   state_t                  state_q, state_d;
   logic [NUM_CORES-1:0]    acq_q, acq_d, req;
   logic [IW-1:0]           g_q, g_d, last_q, last_d, win, idx;
   logic                    is_wr_q, is_wr_d, found;
   logic [NUM_CORES*DW-1:0] dq_q, dq_d;

   function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
      return (i == LAST_IDX) ? '0 : i + 1'b1;
   endfunction

   assign req = rden | wren;

   // Scan all cores once, starting just after the last winner so it ranks lowest.
   always_comb begin
`ifdef DRAM_ARB_FIXED_PRIO_EN
      idx = '0;
`else
      idx = nxt(last_q);
`endif
      win = '0;
      found = 1'b0;
      for (int k = 0; k < NUM_CORES; k++) begin
         if (!found && req[idx]) begin
            win = idx;
            found = 1'b1;
         end
         idx = nxt(idx);
      end
   end

   always_comb begin
      state_d = state_q;
      acq_d = acq_q;
      g_d = g_q;
      last_d = last_q;
      is_wr_d = is_wr_q;
      dq_d = dq_q;
      if (state_q == RDATA) dq_d[g_q*DW +: DW] = RAMq;
      if (state_q == GRANT && !is_wr_q) begin
         state_d = RDATA;
      end else if (found) begin
         state_d = GRANT;
         acq_d = NUM_CORES'(1) << win;
         g_d = win;
         last_d = win;
         is_wr_d = wren[win];
      end else begin
         state_d = IDLE;
         acq_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acq_q <= '0;
         g_q <= '0;
         last_q <= LAST_IDX;
         is_wr_q <= 1'b0;
         dq_q <= '0;
      end else begin
         state_q <= state_d;
         acq_q <= acq_d;
         g_q <= g_d;
         last_q <= last_d;
         is_wr_q <= is_wr_d;
         dq_q <= dq_d;
      end
   end

   assign acq = acq_q;
   assign Dq = dq_q;
   assign RAMAddress = (state_q == IDLE) ? '0 : Address[g_q*AW +: AW];
   assign RAMDin = (state_q == IDLE) ? '0 : Din[g_q*DW +: DW];
   assign RAMwren = (state_q == GRANT) && is_wr_q;
endmodule

// File: tb/tb_dram_arbiter.sv
// tb_dram_arbiter: randomized scoreboard bench; a transaction-level arbiter model predicts each grant.
module tb_dram_arbiter;
   localparam int N = 2, AW = 8, DW = 8;
   logic clk = 0, rst_n = 0;
   logic [N-1:0] rden = '0, wren = '0;
   logic [N*AW-1:0] Address = '0;
   logic [N*DW-1:0] Din = '0;
   logic [DW-1:0] RAMq = '0;
   logic [N-1:0] acq;
   logic [N*DW-1:0] Dq;
   logic [AW-1:0] RAMAddress;
   logic [DW-1:0] RAMDin;
   logic RAMwren;

   always #5 clk = ~clk;

   dram_arbiter #(.NUM_CORES(N), .AW(AW), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .rden(rden), .wren(wren), .Address(Address), .Din(Din),
      .RAMq(RAMq), .acq(acq), .Dq(Dq), .RAMAddress(RAMAddress), .RAMDin(RAMDin), .RAMwren(RAMwren));

   logic [DW-1:0] ram [256];
   logic [DW-1:0] shadow [256];

   always @(posedge clk) begin
      RAMq <= ram[RAMAddress];
      if (RAMwren) ram[RAMAddress] <= RAMDin;
   end

   typedef struct {int core; bit wr; logic [AW-1:0] addr; logic [DW-1:0] din; logic [DW-1:0] rdata;} txn_t;
   txn_t exp_q[$];
   int vectors = 0, errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int pick(input logic [N-1:0] r, input int last);
`ifdef DRAM_ARB_FIXED_PRIO_EN
      for (int i = 0; i < N; i++) if (r[i]) return i;
`else
      for (int k = 1; k <= N; k++) if (r[(last + k) % N]) return (last + k) % N;
`endif
      return -1;
   endfunction

   // Reference model: a transaction occupies 1 cycle (write) or 2 (read); when the
   // arbiter is free at an edge, the next winner is picked from the sampled requests.
   initial begin
      int busy, m_last;
      busy = 0;
      m_last = N - 1;
      forever begin
         @(posedge clk);
         if (!rst_n) begin
            busy = 0;
            m_last = N - 1;
            exp_q.delete();
         end else begin
            if (busy > 0) busy--;
            if (busy == 0 && (rden | wren) != 0) begin
               txn_t t;
               t.core = pick(rden | wren, m_last);
               t.wr = wren[t.core];
               t.addr = Address[t.core*AW +: AW];
               t.din = Din[t.core*DW +: DW];
               t.rdata = shadow[t.addr];
               if (t.wr) shadow[t.addr] = t.din;
               exp_q.push_back(t);
               busy = t.wr ? 1 : 2;
               m_last = t.core;
            end
         end
      end
   end

   // Monitor: compares the DUT against expected transactions mid-cycle.
   initial begin
      int mon_left;
      txn_t cur;
      logic [N*DW-1:0] exp_dq;
      mon_left = 0;
      exp_dq = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            mon_left = 0;
            exp_dq = '0;
         end else begin
            chk("dq", Dq, exp_dq);
            if (mon_left == 0) begin
               if (acq == '0) begin
                  chk("idle_wren", RAMwren, 0);
                  chk("idle_bus", {RAMAddress, RAMDin}, 0);
               end else if (exp_q.size() == 0) begin
                  chk("unexpected_grant", acq, 0);
               end else begin
                  cur = exp_q.pop_front();
                  chk("grant_acq", acq, N'(1) << cur.core);
                  chk("grant_wren", RAMwren, cur.wr);
                  chk("grant_addr", RAMAddress, cur.addr);
                  if (cur.wr) chk("grant_din", RAMDin, cur.din);
                  mon_left = cur.wr ? 0 : 1;
               end
            end else begin
               chk("rdata_acq", acq, N'(1) << cur.core);
               chk("rdata_wren", RAMwren, 0);
               chk("rdata_addr", RAMAddress, cur.addr);
               exp_dq[cur.core*DW +: DW] = cur.rdata;
               mon_left = 0;
            end
         end
      end
   end

   task automatic wait_idle();
      int t = 0;
      while (acq != '0 && t < 40) begin
         @(posedge clk); #2;
         t++;
      end
      chk("release_timeout", acq, 0);
   endtask

   task automatic txn(input int c, input bit rd, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
      int t = 0;
      @(posedge clk); #2;
      rden[c] = rd;
      wren[c] = wr;
      Address[c*AW +: AW] = a;
      Din[c*DW +: DW] = d;
      while (!acq[c] && t < 20) begin
         @(posedge clk); #2;
         t++;
      end
      chk("grant_timeout", acq[c], 1);
      rden[c] = 0;
      wren[c] = 0;
      wait_idle();
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         ram[i] = DW'($urandom);
         shadow[i] = ram[i];
      end
      repeat (2) @(posedge clk);
      #1;
      chk("reset_acq", acq, 0);
      chk("reset_dq", Dq, 0);
      chk("reset_wren", RAMwren, 0);
      @(posedge clk); #2;
      rst_n = 1;
      txn(0, 0, 1, 8'h10, 8'hA5);
      txn(1, 1, 0, 8'h10, 8'h00);
      @(posedge clk); #2;
      rden = '1;
      for (int i = 0; i < N; i++) Address[i*AW +: AW] = AW'($urandom_range(0, 15));
      repeat (12) @(posedge clk);
      #2;
      rden = '0;
      wait_idle();
      txn(0, 1, 1, 8'h22, 8'h5A);
      txn(0, 1, 0, 8'h22, 8'h00);
      for (int cyc = 0; cyc < 600; cyc++) begin
         @(posedge clk); #2;
         for (int i = 0; i < N; i++) begin
            if (!acq[i]) begin
               int r;
               r = $urandom_range(0, 9);
               rden[i] = (r >= 3 && r < 6) || r >= 8;
               wren[i] = r >= 6;
               Address[i*AW +: AW] = AW'($urandom_range(0, 15));
               Din[i*DW +: DW] = DW'($urandom);
            end
         end
      end
      rden = '0;
      wren = '0;
      wait_idle();
      repeat (2) @(posedge clk);
      chk("queue_empty", exp_q.size(), 0);
      // Assert reset in the middle of a write grant.
      @(posedge clk); #2;
      wren[0] = 1;
      Address[AW-1:0] = 8'h33;
      Din[DW-1:0] = 8'h77;
      begin
         int t = 0;
         while (!acq[0] && t < 20) begin
            @(posedge clk); #2;
            t++;
         end
      end
      chk("rst_grant", acq, 1);
      rst_n = 0;
      #1;
      chk("rst_async_acq", acq, 0);
      chk("rst_async_wren", RAMwren, 0);
      chk("rst_async_dq", Dq, 0);
      wren = '0;
      @(posedge clk); #2;
      rst_n = 1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", acq, 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
